// File: rtl/multibyte_add_ctrl_if.sv
// Bundle of request, external-adder and result signals for multibyte_add_ctrl.
// Handshake rule (both request and result channels): a transfer happens at a
// rising clk edge where valid and ready are both 1; the source holds valid and
// its payload steady until that edge, and ready never depends on valid.
interface multibyte_add_ctrl_if #(
    parameter int NBYTES = 4
);
    // request channel
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   op_a;
    logic [8*NBYTES-1:0]   op_b;
    logic                  op_cin;
    // shared external 8-bit adder
    logic [7:0]            add_a;
    logic [7:0]            add_b;
    logic                  add_cin;
    logic [7:0]            add_sum;
    logic                  add_cout;
    // result channel
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   result;
    logic                  out_cout;
    logic                  out_ovf;

    // controller side
    modport slave (
        input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, result, out_cout, out_ovf
    );

    // requester / consumer / adder side
    modport master (
        output in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, result, out_cout, out_ovf
    );
endinterface

// File: rtl/multibyte_add_ctrl.sv
// Sequences a wide add through one shared external 8-bit adder, one byte per
// cycle from byte 0 upward, then holds the result until the consumer takes it.
module multibyte_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multibyte_add_ctrl_if.slave       bus,
    output logic [1:0]                o_dbg_state
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NBYTES-1:0][7:0]  r_a;
    logic [NBYTES-1:0][7:0]  r_b;
    logic [NBYTES-1:0][7:0]  r_result;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_carry;
    logic                    r_out_cout;
    logic                    r_out_ovf;

    logic                    w_last;
    logic                    w_a_msb;
    logic                    w_b_msb;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_a_msb = r_a[NBYTES-1][7];
    assign w_b_msb = r_b[NBYTES-1][7];

    // State register; reset always lands in IDLE, which also blocks a request
    // presented in the same cycle as reset.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake/adder outputs; adder operands come only from
    // captured registers so op_a/op_b/op_cin never reach the adder directly.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_a     = 8'd0;
        bus.add_b     = 8'd0;
        bus.add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                bus.add_a   = r_a[r_idx];
                bus.add_b   = r_b[r_idx];
                bus.add_cin = r_carry;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, byte-serial accumulation, and final flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_carry <= bus.op_cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= bus.add_sum;
                    r_carry         <= bus.add_cout;
                    if (w_last) begin
                        // signed overflow: like-signed operands, differently signed sum
                        r_out_cout <= bus.add_cout;
                        r_out_ovf  <= (w_a_msb == w_b_msb) && (bus.add_sum[7] != w_a_msb);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = r_result;
    assign bus.out_cout = r_out_cout;
    assign bus.out_ovf  = r_out_ovf;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench for multibyte_add_ctrl with NBYTES=4 and a behavioural
// 8-bit adder closing the loop on the external adder port.
module tb_multibyte_add_ctrl;

    localparam int NB = 4;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    multibyte_add_ctrl_if #(.NBYTES(NB)) bus ();

    multibyte_add_ctrl #(.NBYTES(NB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // external simple 8-bit adder
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_state"},     64'(dbg_state),     64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_result"},    64'(bus.result),    64'd0);
        chk({tag, "_cout"},      64'(bus.out_cout),  64'd0);
        chk({tag, "_ovf"},       64'(bus.out_ovf),   64'd0);
        chk({tag, "_add_a"},     64'(bus.add_a),     64'd0);
        chk({tag, "_add_b"},     64'(bus.add_b),     64'd0);
        chk({tag, "_add_cin"},   64'(bus.add_cin),   64'd0);
    endtask

    // Full transaction from IDLE: accept is edge 1, out_valid must appear
    // after edge 5 and not after edge 4; then drain with out_ready.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [31:0] exp_res,
                         input logic exp_cout, input logic exp_ovf);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_run_state"}, 64'(dbg_state),    64'd1);
        chk({tag, "_busy"},      64'(bus.in_ready), 64'd0);
        chk({tag, "_add_a0"},    64'(bus.add_a),    64'(a[7:0]));
        chk({tag, "_add_b0"},    64'(bus.add_b),    64'(b[7:0]));
        chk({tag, "_add_cin0"},  64'(bus.add_cin),  64'(cin));
        tick();
        tick();
        tick();
        chk({tag, "_not_yet"},   64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, "_valid"},     64'(bus.out_valid), 64'd1);
        chk({tag, "_result"},    64'(bus.result),    64'(exp_res));
        chk({tag, "_cout"},      64'(bus.out_cout),  64'(exp_cout));
        chk({tag, "_ovf"},       64'(bus.out_ovf),   64'(exp_ovf));
        chk({tag, "_done_add_a"}, 64'(bus.add_a),    64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_back_idle"}, 64'(dbg_state),     64'd0);
        chk({tag, "_drained"},   64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] held_res;

        // reset with a request asserted in the same cycles: must not be taken
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op_a      = 32'h0000_0055;
        bus.op_b      = 32'h0000_0011;
        bus.op_cin    = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        tick();
        chk_idle_zero("reset");
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        chk("post_reset_state", 64'(dbg_state), 64'd0);

        // basic carry between bytes
        do_op("basic",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        // full ripple from carry-in
        do_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        // signed overflow, positive
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        // signed overflow, negative with carry-out
        do_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        // mixed bytes, no flags
        do_op("mixed",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // backpressure: hold result for 10 cycles, pulse an ignored request
        bus.in_valid = 1'b1;
        bus.op_a     = 32'h0102_0304;
        bus.op_b     = 32'h1010_1010;
        bus.op_cin   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        held_res = 32'h1112_1315;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 5);
            bus.op_a     = 32'hDEAD_BEEF;
            chk("bp_result",   64'(bus.result),    64'(held_res));
            chk("bp_in_ready", 64'(bus.in_ready),  64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_cout",     64'(bus.out_cout),  64'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_idle", 64'(dbg_state), 64'd0);
        tick();
        chk("bp_no_accept", 64'(dbg_state), 64'd0);

        // reset in the middle of RUN at idx=2
        bus.in_valid = 1'b1;
        bus.op_a     = 32'hAAAA_AAAA;
        bus.op_b     = 32'h5555_5555;
        bus.op_cin   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid_rst_run", 64'(dbg_state), 64'd1);
        rst_n = 1'b0;
        tick();
        chk_idle_zero("mid_rst");
        rst_n = 1'b1;
        tick();
        do_op("after_rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

        // back-to-back with in_valid held high; operands change during RUN
        bus.in_valid = 1'b1;
        bus.op_a     = 32'h1234_5678;
        bus.op_b     = 32'h1111_1111;
        bus.op_cin   = 1'b0;
        tick();
        bus.op_a   = 32'hF000_0000;
        bus.op_b   = 32'h2000_0000;
        bus.op_cin = 1'b0;
        tick(); tick(); tick(); tick();
        chk("b2b1_valid",  64'(bus.out_valid), 64'd1);
        chk("b2b1_result", 64'(bus.result),    64'h2345_6789);
        chk("b2b1_cout",   64'(bus.out_cout),  64'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("b2b_gap_idle", 64'(dbg_state), 64'd0);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("b2b2_accepted", 64'(dbg_state), 64'd1);
        chk("b2b2_add_b0",   64'(bus.add_b), 64'h00);
        tick(); tick(); tick();
        chk("b2b2_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        chk("b2b2_valid",  64'(bus.out_valid), 64'd1);
        chk("b2b2_result", 64'(bus.result),    64'h1000_0000);
        chk("b2b2_cout",   64'(bus.out_cout),  64'd1);
        chk("b2b2_ovf",    64'(bus.out_ovf),   64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("final_idle", 64'(dbg_state), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
